// File: rtl/real_capture_pkg.sv
// real_capture_pkg: state encoding shared by the real capture buffer
package real_capture_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, CAPTURE = 2'd2, DONE = 2'd3} state_t;
endpackage

// File: rtl/real_capture_mem.sv
// real_capture_mem: simple dual-port sample RAM with registered read (read-before-write, read register reset)
module real_capture_mem #(
  parameter int DEPTH_LOG2 = 2,
  parameter int WIDTH = 25
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_we,
  input  logic [DEPTH_LOG2-1:0] i_waddr,
  input  logic [WIDTH-1:0]      i_wdata,
  input  logic [DEPTH_LOG2-1:0] i_raddr,
  output logic [WIDTH-1:0]      o_rdata
);
  logic [WIDTH-1:0] r_mem [2**DEPTH_LOG2];
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end
  always_ff @(posedge clk) begin
    o_rdata <= rst ? '0 : r_mem[i_raddr];
  end
endmodule

// File: rtl/real_capture_buffer.sv
// real_capture_buffer: armed/triggered capture of DEPTH real samples; REAL_CAPTURE_OVF_EN adds sticky ovf output
module real_capture_buffer
  import real_capture_pkg::*;
#(
  parameter int DEPTH_LOG2 = 2,
  parameter int WIDTH = 25,
  parameter int EXPONENT = -16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WIDTH-1:0]      in_data,
  input  logic                  in_valid,
  input  logic                  arm,
  input  logic                  trig,
  input  logic [DEPTH_LOG2-1:0] rd_addr,
  output logic [WIDTH-1:0]      rd_data,
  output logic                  done,
  output logic [DEPTH_LOG2:0]   wr_count
`ifdef REAL_CAPTURE_OVF_EN
  ,
  output logic                  ovf
`endif
);
  localparam int CW = DEPTH_LOG2 + 1;
  state_t r_state, w_next;
  logic [CW-1:0] r_cnt, w_next_cnt, w_cnt_inc;
  logic w_we, w_rearm;
  always_comb begin
    w_cnt_inc = r_cnt + CW'(1);
    w_rearm = arm && (r_state == IDLE || r_state == DONE);
    w_we = !rst && in_valid && ((r_state == ARMED && trig) || r_state == CAPTURE);
    w_next = w_rearm ? ARMED : w_we ? (w_cnt_inc == CW'(2**DEPTH_LOG2) ? DONE : CAPTURE) : r_state;
    w_next_cnt = w_rearm ? '0 : w_we ? w_cnt_inc : r_cnt;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt <= '0;
    end else begin
      r_state <= w_next;
      r_cnt <= w_next_cnt;
    end
  end
  assign done = r_state == DONE;
  assign wr_count = r_cnt;
`ifdef REAL_CAPTURE_OVF_EN
  logic r_ovf;
  always_ff @(posedge clk) begin
    r_ovf <= (rst || arm) ? 1'b0 : (r_state == DONE && in_valid) ? 1'b1 : r_ovf;
  end
  assign ovf = r_ovf;
`endif
  real_capture_mem #(.DEPTH_LOG2(DEPTH_LOG2), .WIDTH(WIDTH)) u_mem (
    .clk(clk),
    .rst(rst),
    .i_we(w_we),
    .i_waddr(r_cnt[DEPTH_LOG2-1:0]),
    .i_wdata(in_data),
    .i_raddr(rd_addr),
    .o_rdata(rd_data)
  );
endmodule

// File: doc/real_capture_buffer.md
REAL_CAPTURE_BUFFER -- requirements
Module: real_capture_buffer

Interface
REQ-001 Parameter DEPTH_LOG2, default 2: log2 of the buffer depth; DEPTH = 2**DEPTH_LOG2.
REQ-002 Parameter WIDTH, default 25: width of the signed fixed-point real sample.
REQ-003 Parameter EXPONENT, default -16: fixed-point exponent of the sample; the block passes it through unused in arithmetic, for PASS_REAL-compatible instantiation.
REQ-004 Port clk  input  1  clock; all state changes on its rising edge.
REQ-005 Port rst  input  1  reset, synchronous, active-high.
REQ-006 Port in_data  input  WIDTH  signed fixed-point sample to capture.
REQ-007 Port in_valid  input  1  in_data is valid this cycle.
REQ-008 Port arm  input  1  single-cycle request to start a new capture.
REQ-009 Port trig  input  1  capture trigger, sampled only in ARMED.
REQ-010 Port rd_addr  input  DEPTH_LOG2  readout address.
REQ-011 Port rd_data  output  WIDTH  sample stored at the previous cycle's rd_addr.
REQ-012 Port done  output  1  high while in DONE.
REQ-013 Port wr_count  output  DEPTH_LOG2+1  number of samples written in the current capture.

Function
REQ-014 FSM states SHALL be IDLE, ARMED, CAPTURE and DONE.
REQ-015 IDLE: arm -> ARMED with wr_count cleared to 0; all other inputs ignored.
REQ-016 ARMED: trig & in_valid -> write in_data at address 0, set wr_count=1, go to CAPTURE; trig without in_valid stays in ARMED and is not remembered.
REQ-017 CAPTURE: each in_valid writes in_data at address wr_count[DEPTH_LOG2-1:0] and increments wr_count; the write that makes wr_count==DEPTH goes to DONE in the same edge.
REQ-018 CAPTURE: arm and trig ignored; in_valid gaps hold state and wr_count.
REQ-019 DONE: done=1, no writes; arm -> ARMED with wr_count=0; stored samples are kept until overwritten.
REQ-020 Arm and trig in the same cycle in IDLE or DONE: arm acts, trig ignored; capture starts on a later trig.
REQ-021 Samples SHALL be stored bit-exact, without scaling or saturation.
REQ-022 Read latency SHALL be one cycle, available in every state; a read and write to the same address in one cycle returns the old contents.
REQ-023 rd_addr wraps naturally over DEPTH_LOG2 bits; no out-of-range case exists.

Reset
REQ-024 rst SHALL force IDLE, wr_count=0, done=0 and rd_data=0 at the next edge, including mid-capture.
REQ-025 Buffer contents are not cleared by reset; they read undefined until written.

Configuration
REQ-026 With macro REAL_CAPTURE_OVF_EN defined, the block SHALL add output port ovf (1 bit), set sticky when in_valid is high in DONE and cleared by arm or rst; it resets to 0.
REQ-027 Without REAL_CAPTURE_OVF_EN, port ovf and its logic SHALL be absent, with all other behaviour identical.

Structure
REQ-028 Package real_capture_pkg SHALL hold the state enum typedef (IDLE=0, ARMED=1, CAPTURE=2, DONE=3).
REQ-029 Storage SHALL be sub-module real_capture_mem: simple dual-port RAM, parameterised by DEPTH_LOG2 and WIDTH, with a synchronous registered read.
REQ-030 The top level SHALL contain only the FSM, wr_count, the write enable and the optional ovf.

Verification (DEPTH_LOG2=2, WIDTH=25, EXPONENT=-16)
REQ-031 Reset, arm, then trig with in_valid and samples 10.0, 20.0, -5.0, 0.5 (655360, 1310720, -327680, 32768) -> done=1 after the 4th write, wr_count=4; reading addresses 0..3 returns those values one cycle after each address.
REQ-032 Extra in_valid sample 3.0 after DONE -> buffer unchanged and done stays 1; with REAL_CAPTURE_OVF_EN, ovf=1 until the next arm.
REQ-033 Trig in ARMED with in_valid=0, then in_valid without trig -> no write, wr_count=0, state stays ARMED.
REQ-034 rst asserted after 2 writes -> IDLE, wr_count=0, done=0; a new arm and 4-sample capture completes normally.
REQ-035 Arm and trig in the same IDLE cycle -> no write; a trig two cycles later starts capture at address 0.
REQ-036 rd_addr equal to the write address in the same cycle -> rd_data shows the previous contents, then the new value on the following read.
